// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 timing constants, the derived totals and
//               sync-window bounds, plus small helpers for deriving them.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package vga_timing_pkg;

    // Default horizontal geometry (pixels)
    localparam int c_h_display = 640;
    localparam int c_h_front   = 16;
    localparam int c_h_sync    = 96;
    localparam int c_h_back    = 48;

    // Default vertical geometry (lines)
    localparam int c_v_display = 480;
    localparam int c_v_bottom  = 10;
    localparam int c_v_sync    = 2;
    localparam int c_v_top     = 33;

    // Total line length / frame height of a timing set
    function automatic int total_of(input int disp, input int porch_a,
                                    input int sync, input int porch_b);
        return disp + porch_a + sync + porch_b;
    endfunction

    // First and last position of a sync window
    function automatic int sync_first(input int disp, input int porch);
        return disp + porch;
    endfunction

    function automatic int sync_last(input int disp, input int porch, input int sync);
        return disp + porch + sync - 1;
    endfunction

    localparam int c_h_total    = total_of(c_h_display, c_h_front, c_h_sync, c_h_back);
    localparam int c_v_total    = total_of(c_v_display, c_v_bottom, c_v_sync, c_v_top);
    localparam int c_hs_start   = sync_first(c_h_display, c_h_front);
    localparam int c_hs_end     = sync_last(c_h_display, c_h_front, c_h_sync);
    localparam int c_vs_start   = sync_first(c_v_display, c_v_bottom);
    localparam int c_vs_end     = sync_last(c_v_display, c_v_bottom, c_v_sync);

endpackage
`default_nettype wire

// File: rtl/vga_pix_div.sv
`default_nettype none
// ============================================================================
// Module      : vga_pix_div
// Description : Pixel-clock divider. Produces a one-clk tick every PIX_DIV
//               clocks; a constant 1 when PIX_DIV is 1.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pix_div #(
    parameter int PIX_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    generate
        if (PIX_DIV <= 1) begin : g_passthru
            // Every clock is a pixel; clk and reset are intentionally unused.
            logic w_unused;
            assign w_unused = &{1'b0, clk, reset};
            assign tick     = 1'b1;
        end else begin : g_count
            localparam int              c_dw   = $clog2(PIX_DIV);
            localparam logic [c_dw-1:0] c_last = c_dw'(PIX_DIV - 1);

            logic [c_dw-1:0] r_div;

            // Free-running 0..PIX_DIV-1 phase counter, cleared by reset
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_div <= '0;
                end else if (r_div == c_last) begin
                    r_div <= '0;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end

            assign tick = (r_div == c_last);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA raster timing generator. Position, sync,
//               blanking and strobes all come from one register stage.
//               Optional macro VGA_TIMING_FRAME_CNT_EN enables frame_count;
//               without it frame_count is tied to zero.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY  = c_h_display,
    parameter int H_FRONT    = c_h_front,
    parameter int H_SYNC     = c_h_sync,
    parameter int H_BACK     = c_h_back,
    parameter int V_DISPLAY  = c_v_display,
    parameter int V_BOTTOM   = c_v_bottom,
    parameter int V_SYNC     = c_v_sync,
    parameter int V_TOP      = c_v_top,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int PIX_DIV    = 1,
    parameter int CW         = 10,
    parameter int FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    output logic [CW-1:0]      haddr,
    output logic [CW-1:0]      vaddr,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               pix_en,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int c_h_tot = total_of(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int c_v_tot = total_of(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);

    // Decode constants are one bit wider than the counters so a display
    // width equal to 2^CW still compares correctly.
    localparam logic [CW:0]   c_hd_x   = (CW+1)'(H_DISPLAY);
    localparam logic [CW:0]   c_vd_x   = (CW+1)'(V_DISPLAY);
    localparam logic [CW:0]   c_hs_s_x = (CW+1)'(sync_first(H_DISPLAY, H_FRONT));
    localparam logic [CW:0]   c_hs_e_x = (CW+1)'(sync_last(H_DISPLAY, H_FRONT, H_SYNC));
    localparam logic [CW:0]   c_vs_s_x = (CW+1)'(sync_first(V_DISPLAY, V_BOTTOM));
    localparam logic [CW:0]   c_vs_e_x = (CW+1)'(sync_last(V_DISPLAY, V_BOTTOM, V_SYNC));
    localparam logic [CW-1:0] c_h_last = CW'(c_h_tot - 1);
    localparam logic [CW-1:0] c_v_last = CW'(c_v_tot - 1);

    generate
        if ((c_h_tot > (1 << CW)) || (c_v_tot > (1 << CW))) begin : g_bad_cw
            $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
        end
    endgenerate

    logic          w_tick;
    logic [CW-1:0] r_hcnt;
    logic [CW-1:0] r_vcnt;
    logic [CW:0]   w_hx;
    logic [CW:0]   w_vx;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_de;
    logic          w_line;
    logic          w_frame;

    vga_pix_div #(
        .PIX_DIV (PIX_DIV)
    ) u_pix_div (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_hx     = {1'b0, r_hcnt};
    assign w_vx     = {1'b0, r_vcnt};
    assign w_hs_act = (w_hx >= c_hs_s_x) && (w_hx <= c_hs_e_x);
    assign w_vs_act = (w_vx >= c_vs_s_x) && (w_vx <= c_vs_e_x);
    assign w_de     = (w_hx < c_hd_x) && (w_vx < c_vd_x);
    assign w_line   = (r_hcnt == '0);
    assign w_frame  = w_line && (r_vcnt == '0);

    // Raster position counters: advance one pixel per tick, wrap per line/frame
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_tick) begin
            if (r_hcnt == c_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= (r_vcnt == c_v_last) ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    // Output stage: load the decode of the current position on each tick
    always_ff @(posedge clk) begin
        if (reset) begin
            haddr       <= '0;
            vaddr       <= '0;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            display_on  <= 1'b0;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (w_tick) begin
            haddr       <= r_hcnt;
            vaddr       <= r_vcnt;
            hsync       <= w_hs_act ? H_SYNC_POL : ~H_SYNC_POL;
            vsync       <= w_vs_act ? V_SYNC_POL : ~V_SYNC_POL;
            display_on  <= w_de;
            pix_en      <= 1'b1;
            line_start  <= w_line;
            frame_start <= w_frame;
        end else begin
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic               r_fc_armed;
    logic [FRAME_W-1:0] r_frame_count;

    // Count completed frames; the first frame_start after reset only arms
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fc_armed    <= 1'b0;
            r_frame_count <= '0;
        end else if (w_tick && w_frame) begin
            r_fc_armed <= 1'b1;
            if (r_fc_armed) begin
                r_frame_count <= r_frame_count + 1'b1;
            end
        end
    end

    assign frame_count = r_frame_count;
`else
    assign frame_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. Two instances with a
//               tiny 14x8 raster: A (PIX_DIV=1, active-low syncs, FRAME_W=2)
//               and B (PIX_DIV=2, active-high syncs, FRAME_W=3). A frame-index
//               model predicts every output each cycle; literal per-frame
//               totals pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int HD = 8, HF = 2, HS = 3, HB = 1;
    localparam int VD = 4, VB = 1, VS = 2, VT = 1;
    localparam int HTOT = HD + HF + HS + HB;   // 14
    localparam int VTOT = VD + VB + VS + VT;   // 8

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] a_h, a_v;
    logic       a_hs, a_vs, a_de, a_pe, a_ls, a_fs;
    logic [1:0] a_fc;
    logic [4:0] b_h, b_v;
    logic       b_hs, b_vs, b_de, b_pe, b_ls, b_fs;
    logic [2:0] b_fc;

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
        .PIX_DIV(1), .CW(4), .FRAME_W(2)
    ) u_dut_a (
        .clk(clk), .reset(reset), .haddr(a_h), .vaddr(a_v),
        .hsync(a_hs), .vsync(a_vs), .display_on(a_de), .pix_en(a_pe),
        .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
    );

    vga_timing_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
        .PIX_DIV(2), .CW(5), .FRAME_W(3)
    ) u_dut_b (
        .clk(clk), .reset(reset), .haddr(b_h), .vaddr(b_v),
        .hsync(b_hs), .vsync(b_vs), .display_on(b_de), .pix_en(b_pe),
        .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (frame-index arithmetic) ----------------
    int  m_pd  [2] = '{1, 2};
    bit  m_pol [2] = '{1'b0, 1'b1};
    int  m_fw  [2] = '{2, 3};
    int  m_phase [2];
    int  m_next  [2];
    int  m_fc    [2];
    bit  m_first [2];
    int  e_h [2], e_v [2], e_fc [2];
    bit  e_hs [2], e_vs [2], e_de [2], e_pe [2], e_ls [2], e_fs [2];
    bit  m_valid = 1'b0;
    bit  rst_q = 1'b1, rst_prev = 1'b1;
    int  p_loc, h_loc, v_loc;
    bit  tk;

    always @(posedge clk) begin
        rst_prev = rst_q;
        rst_q    = reset;
        if (reset) m_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_phase[i] = 0; m_next[i] = 0; m_fc[i] = 0; m_first[i] = 1'b1;
                e_h[i] = 0; e_v[i] = 0; e_fc[i] = 0;
                e_hs[i] = ~m_pol[i]; e_vs[i] = ~m_pol[i];
                e_de[i] = 0; e_pe[i] = 0; e_ls[i] = 0; e_fs[i] = 0;
            end else begin
                tk = (m_phase[i] == m_pd[i] - 1);
                m_phase[i] = (m_phase[i] + 1) % m_pd[i];
                if (tk) begin
                    p_loc = m_next[i];
                    h_loc = p_loc % HTOT;
                    v_loc = p_loc / HTOT;
                    m_next[i] = (p_loc + 1) % (HTOT * VTOT);
                    e_h[i]  = h_loc;
                    e_v[i]  = v_loc;
                    e_hs[i] = (h_loc >= HD + HF && h_loc < HD + HF + HS) ? m_pol[i] : ~m_pol[i];
                    e_vs[i] = (v_loc >= VD + VB && v_loc < VD + VB + VS) ? m_pol[i] : ~m_pol[i];
                    e_de[i] = (h_loc < HD) && (v_loc < VD);
                    e_pe[i] = 1'b1;
                    e_ls[i] = (h_loc == 0);
                    e_fs[i] = (p_loc == 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
                    if (p_loc == 0) begin
                        if (m_first[i]) m_first[i] = 1'b0;
                        else m_fc[i] = (m_fc[i] + 1) % (1 << m_fw[i]);
                    end
                    e_fc[i] = m_fc[i];
`endif
                end else begin
                    e_pe[i] = 1'b0; e_ls[i] = 1'b0; e_fs[i] = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("a_haddr", a_h, e_h[0]);   chk("a_vaddr", a_v, e_v[0]);
            chk("a_hsync", a_hs, e_hs[0]); chk("a_vsync", a_vs, e_vs[0]);
            chk("a_de", a_de, e_de[0]);    chk("a_pix_en", a_pe, e_pe[0]);
            chk("a_line", a_ls, e_ls[0]);  chk("a_frame", a_fs, e_fs[0]);
            chk("a_fcount", a_fc, e_fc[0]);
            chk("b_haddr", b_h, e_h[1]);   chk("b_vaddr", b_v, e_v[1]);
            chk("b_hsync", b_hs, e_hs[1]); chk("b_vsync", b_vs, e_vs[1]);
            chk("b_de", b_de, e_de[1]);    chk("b_pix_en", b_pe, e_pe[1]);
            chk("b_line", b_ls, e_ls[1]);  chk("b_frame", b_fs, e_fs[1]);
            chk("b_fcount", b_fc, e_fc[1]);
        end
    end

    // ---------------- literal per-frame expectations ----------------
    int cyc = 0;
    int last_fs [2];
    bit clean   [2];
    int nframes [2];
    int de_cnt [2], hs_cnt [2], vs_cnt [2];

    task automatic lit(input int i, input bit fs, input bit de, input bit hs,
                       input bit vs, input int fc, input int h, input int v);
        if (fs) begin
            if (clean[i]) begin
                chk(i == 0 ? "a_frame_period" : "b_frame_period", cyc - last_fs[i], i == 0 ? 112 : 224);
                chk(i == 0 ? "a_de_per_frame" : "b_de_per_frame", de_cnt[i], i == 0 ? 32 : 64);
                chk(i == 0 ? "a_hs_per_frame" : "b_hs_per_frame", hs_cnt[i], i == 0 ? 24 : 48);
                chk(i == 0 ? "a_vs_per_frame" : "b_vs_per_frame", vs_cnt[i], i == 0 ? 28 : 56);
            end
            chk(i == 0 ? "a_fs_pos" : "b_fs_pos", {h[15:0], v[15:0]}, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk(i == 0 ? "a_fc_seq" : "b_fc_seq", fc, nframes[i] % (i == 0 ? 4 : 8));
`else
            chk(i == 0 ? "a_fc_zero" : "b_fc_zero", fc, 0);
`endif
            nframes[i]++;
            clean[i]   = 1'b1;
            last_fs[i] = cyc;
            de_cnt[i] = 0; hs_cnt[i] = 0; vs_cnt[i] = 0;
        end
        if (de) de_cnt[i]++;
        if (hs == (i == 1)) hs_cnt[i]++;
        if (vs == (i == 1)) vs_cnt[i]++;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (m_valid) begin
            if (rst_q) begin
                clean[0] = 1'b0; clean[1] = 1'b0;
                nframes[0] = 0;  nframes[1] = 0;
                chk("a_rst_hsync", a_hs, 1); chk("a_rst_vsync", a_vs, 1);
                chk("b_rst_hsync", b_hs, 0); chk("b_rst_vsync", b_vs, 0);
                chk("a_rst_strobes", {a_pe, a_ls, a_fs, a_de}, 0);
            end else begin
                if (rst_prev) begin
                    chk("a_first_fs", a_fs, 1);  chk("a_first_ls", a_ls, 1);
                    chk("a_first_de", a_de, 1);  chk("a_first_pos", {a_h, a_v}, 0);
                    chk("b_first_idle", b_pe, 0);
                end
                lit(0, a_fs, a_de, a_hs, a_vs, int'(a_fc), int'(a_h), int'(a_v));
                lit(1, b_fs, b_de, b_hs, b_vs, int'(b_fc), int'(b_h), int'(b_v));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (900) @(negedge clk);
        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(30, 500)) @(negedge clk);
            reset = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            reset = 1'b0;
        end
        repeat (500) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
